// File: rtl/package_read_control.sv
// Read-side sequencer for the even/odd package buffers: counts completed packages and
// streams each one out as even[0],odd[0],even[1],odd[1],... on a valid/ready port.
module package_read_control #(
   parameter int RD_LATENCY = 2,
   parameter int PEND_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  live_rising,
   input  logic                  complete,
   input  logic [9:0]            HALF_PACKAGE_LENGTH,
   input  logic [14:0]           MEMORY_DEPTH,
   output logic [14:0]           even_rdaddr,
   output logic [14:0]           odd_rdaddr,
   input  logic [15:0]           even_q,
   input  logic [15:0]           odd_q,
   output logic [15:0]           tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic [PEND_WIDTH-1:0] pending,
   output logic                  overflow,
   output logic                  busy
);

   // Stream handshake: a word moves on any clock where tx_valid && tx_ready; once
   // tx_valid rises it stays high with tx_data/tx_last frozen until that transfer.
   localparam int FIFO_DEPTH = RD_LATENCY + 2;
   localparam int IDX_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};
   localparam logic [RD_LATENCY-1:0] TOP_STAGE = RD_LATENCY'(1) << (RD_LATENCY - 1);

   typedef enum logic {IDLE, READ} state_t;

   state_t                 state, state_nxt;
   logic [10:0]            len, k;
   logic [RD_LATENCY-1:0]  pipe_vld, pipe_odd, pipe_last;
   logic [15:0]            fifo_data [FIFO_DEPTH];
   logic                   fifo_last [FIFO_DEPTH];
   logic [IDX_W-1:0]       wr_idx, rd_idx;
   logic [CNT_W-1:0]       count, count_nxt, outstanding;
   logic                   pend_inc, pend_dec, load_len, issue, is_last;
   logic                   credit, push, pop, inflight_nxt;
   logic [15:0]            push_data;

   function automatic logic [14:0] ptr_inc(input logic [14:0] p);
      return (p < MEMORY_DEPTH - 15'd1) ? p + 15'd1 : 15'd0;
   endfunction

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(FIFO_DEPTH - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   always_comb begin
      outstanding = '0;
      for (int i = 0; i < RD_LATENCY; i++) outstanding = outstanding + CNT_W'(pipe_vld[i]);
   end

   // Reads in flight are counted against the FIFO so tx_ready=0 can never overfill it.
   assign credit    = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
   assign is_last   = (k == len - 11'd1);
   assign push      = pipe_vld[RD_LATENCY-1];
   assign push_data = pipe_odd[RD_LATENCY-1] ? odd_q : even_q;
   assign pop       = tx_valid && tx_ready;
   assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      state_nxt = state;
      pend_inc  = complete;
      pend_dec  = 1'b0;
      load_len  = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            // A zero-length package is consumed here without ever entering READ.
            if (pending != '0) begin
               pend_dec = 1'b1;
               if (HALF_PACKAGE_LENGTH != 10'd0) begin
                  state_nxt = READ;
                  load_len  = 1'b1;
               end
            end
         end
         READ: begin
            if (credit) begin
               issue = 1'b1;
               if (is_last) begin
                  if (pending != '0 && HALF_PACKAGE_LENGTH != 10'd0) begin
                     pend_dec = 1'b1;
                     load_len = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign inflight_nxt = issue || (|(pipe_vld & ~TOP_STAGE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         even_rdaddr <= '0;
         odd_rdaddr  <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
         len         <= '0;
         k           <= '0;
         pipe_vld    <= '0;
         pipe_odd    <= '0;
         pipe_last   <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         count       <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
      end else if (live_rising) begin
         // Clearing pipe_vld drops the tag of every issued read, so late q data is ignored.
         state       <= IDLE;
         even_rdaddr <= '0;
         odd_rdaddr  <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
         len         <= '0;
         k           <= '0;
         pipe_vld    <= '0;
         pipe_odd    <= '0;
         pipe_last   <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         count       <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (issue && k[0]) begin
            even_rdaddr <= ptr_inc(even_rdaddr);
            odd_rdaddr  <= ptr_inc(odd_rdaddr);
         end
         if (pend_inc && !pend_dec) begin
            if (pending == PEND_MAX) overflow <= 1'b1;
            else pending <= pending + PEND_WIDTH'(1);
         end else if (pend_dec && !pend_inc) begin
            pending <= pending - PEND_WIDTH'(1);
         end
         if (load_len) begin
            len <= {HALF_PACKAGE_LENGTH, 1'b0};
            k   <= '0;
         end else if (issue) begin
            k <= k + 11'd1;
         end
         pipe_vld[0]  <= issue;
         pipe_odd[0]  <= k[0];
         pipe_last[0] <= issue && is_last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_odd[i]  <= pipe_odd[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
         if (push) wr_idx <= idx_inc(wr_idx);
         if (pop) rd_idx <= idx_inc(rd_idx);
         count    <= count_nxt;
         tx_valid <= (count_nxt != '0);
         busy     <= (state_nxt == READ) || (count_nxt != '0) || inflight_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_idx] <= push_data;
         fifo_last[wr_idx] <= pipe_last[RD_LATENCY-1];
      end
   end

   // Storage is unreset, so the head is gated to keep idle outputs at zero.
   assign tx_data = tx_valid ? fifo_data[rd_idx] : 16'd0;
   assign tx_last = tx_valid && fifo_last[rd_idx];

endmodule

// File: tb/tb_package_read_control.sv
// Directed bench for package_read_control with a behavioral even/odd RAM model
// (data = 0xA000+addr for even, 0xB000+addr for odd).
module tb_package_read_control;
   localparam int RL = 2;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          live_rising = 1'b0;
   logic          complete = 1'b0;
   logic          tx_ready = 1'b0;
   logic [9:0]    half = 10'd4;
   logic [14:0]   mdepth = 15'd100;
   logic [14:0]   even_rdaddr, odd_rdaddr;
   logic [15:0]   even_q, odd_q, tx_data;
   logic          tx_valid, tx_last, overflow, busy;
   logic [PW-1:0] pending;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stall_err = 0;
   logic [15:0] got_d[$];
   logic        got_l[$];
   int          got_c[$];
   logic [15:0] exp_q[$];
   logic        exp_l[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'd0;
   logic [14:0] ea_d [RL];
   logic [14:0] oa_d [RL];

   package_read_control #(.RD_LATENCY(RL), .PEND_WIDTH(PW)) dut (
      .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .complete(complete),
      .HALF_PACKAGE_LENGTH(half), .MEMORY_DEPTH(mdepth),
      .even_rdaddr(even_rdaddr), .odd_rdaddr(odd_rdaddr), .even_q(even_q), .odd_q(odd_q),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
      .pending(pending), .overflow(overflow), .busy(busy)
   );

   // clock / reset-independent infrastructure
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      ea_d[0] <= even_rdaddr;
      oa_d[0] <= odd_rdaddr;
      for (int i = 1; i < RL; i++) begin
         ea_d[i] <= ea_d[i-1];
         oa_d[i] <= oa_d[i-1];
      end
   end
   assign even_q = 16'hA000 + {1'b0, ea_d[RL-1]};
   assign odd_q  = 16'hB000 + {1'b0, oa_d[RL-1]};

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_valid && tx_ready) begin
            got_d.push_back(tx_data);
            got_l.push_back(tx_last);
            got_c.push_back(cyc);
         end
         if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_capture();
      got_d.delete();
      got_l.delete();
      got_c.delete();
      exp_q.delete();
      exp_l.delete();
      stall_err = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      live_rising = 1'b0;
      complete = 1'b0;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_capture();
   endtask

   task automatic pulse_complete(input int gap);
      complete = 1'b1;
      tick();
      complete = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_words(input int n, input int budget, input string name);
      int t;
      t = 0;
      while (got_d.size() < n && t < budget) begin
         tick();
         t++;
      end
      checks++;
      if (got_d.size() < n) begin
         errors++;
         $display("FAIL %s_timeout got %0d words required %0d", name, got_d.size(), n);
      end
   endtask

   task automatic build_exp(input int start, input int md, input int npkg, input int hl);
      int a;
      a = start;
      for (int p = 0; p < npkg; p++) begin
         for (int j = 0; j < hl; j++) begin
            exp_q.push_back(16'hA000 + 16'(a));
            exp_l.push_back(1'b0);
            exp_q.push_back(16'hB000 + 16'(a));
            exp_l.push_back(j == hl - 1);
            a = (a < md - 1) ? a + 1 : 0;
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      half = 10'd4;
      mdepth = 15'd100;
      rst_n = 1'b0;
      #3;
      checks++;
      if ({tx_valid, tx_last, overflow, busy} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b required 0000", {tx_valid, tx_last, overflow, busy});
      end
      checks++;
      if (tx_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h required 0000", tx_data); end
      checks++;
      if (pending !== '0) begin errors++; $display("FAIL reset_pending got %0d required 0", pending); end
      checks++;
      if (even_rdaddr !== 15'd0 || odd_rdaddr !== 15'd0) begin
         errors++;
         $display("FAIL reset_addr got %0d/%0d required 0/0", even_rdaddr, odd_rdaddr);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      tx_ready = 1'b1;
      complete = 1'b1;
      tick();
      complete = 1'b0;
      checks++;
      if (pending !== 4'd1) begin errors++; $display("FAIL single_pending_up got %0d required 1", pending); end
      tick();
      checks++;
      if (pending !== 4'd0 || even_rdaddr !== 15'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_enter_read got pend %0d addr %0d busy %b required 0 0 1", pending, even_rdaddr, busy);
      end
      repeat (2) tick();
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b required 0", tx_valid); end
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'hA000) begin
         errors++;
         $display("FAIL single_first_word got %b/%h required 1/a000", tx_valid, tx_data);
      end
      wait_words(8, 60, "single");
      repeat (4) tick();
      build_exp(0, 100, 1, 4);
      checks++;
      if (got_d.size() != exp_q.size()) begin
         errors++;
         $display("FAIL single_count got %0d required %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL single_word%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]);
         end
      end
      checks++;
      if (even_rdaddr !== 15'd4 || odd_rdaddr !== 15'd4) begin
         errors++;
         $display("FAIL single_ptr_end got %0d/%0d required 4/4", even_rdaddr, odd_rdaddr);
      end
      checks++;
      if (pending !== 4'd0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle_end got pend %0d busy %b valid %b required 0 0 0", pending, busy, tx_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      tx_ready = 1'b1;
      repeat (3) pulse_complete(1);
      wait_words(24, 120, "b2b");
      repeat (4) tick();
      build_exp(0, 100, 3, 4);
      checks++;
      if (got_d.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count got %0d required %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL b2b_word%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]);
         end
      end
      if (got_c.size() >= 24) begin
         checks++;
         if (got_c[23] - got_c[0] != 23) begin
            errors++;
            $display("FAIL b2b_gapless got span %0d required 23", got_c[23] - got_c[0]);
         end
      end
   endtask

   task automatic test_wrap();
      mdepth = 15'd6;
      do_reset();
      tx_ready = 1'b1;
      repeat (2) pulse_complete(1);
      wait_words(16, 100, "wrap");
      repeat (4) tick();
      checks++;
      if (got_d.size() != 16) begin
         errors++;
         $display("FAIL wrap_count got %0d required 16", got_d.size());
      end else begin
         checks++;
         if (got_d[8] !== 16'hA004 || got_d[10] !== 16'hA005 || got_d[12] !== 16'hA000 || got_d[14] !== 16'hA001) begin
            errors++;
            $display("FAIL wrap_even_addrs got %h %h %h %h required a004 a005 a000 a001", got_d[8], got_d[10], got_d[12], got_d[14]);
         end
         checks++;
         if (got_d[9] !== 16'hB004 || got_d[11] !== 16'hB005 || got_d[13] !== 16'hB000 || got_d[15] !== 16'hB001) begin
            errors++;
            $display("FAIL wrap_odd_addrs got %h %h %h %h required b004 b005 b000 b001", got_d[9], got_d[11], got_d[13], got_d[15]);
         end
         checks++;
         if (got_l[7] !== 1'b1 || got_l[15] !== 1'b1 || got_l[12] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_last got %b %b %b required 1 1 0", got_l[7], got_l[15], got_l[12]);
         end
      end
      checks++;
      if (even_rdaddr !== 15'd2 || odd_rdaddr !== 15'd2) begin
         errors++;
         $display("FAIL wrap_ptr_end got %0d/%0d required 2/2", even_rdaddr, odd_rdaddr);
      end
      mdepth = 15'd100;
   endtask

   task automatic test_backpressure();
      int held;
      do_reset();
      tx_ready = 1'b1;
      repeat (2) pulse_complete(1);
      for (int i = 0; i < 16; i++) begin
         tx_ready = (i % 2 == 0);
         tick();
      end
      tx_ready = 1'b0;
      tick();
      held = got_d.size();
      repeat (20) tick();
      checks++;
      if (got_d.size() != held || tx_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold got words %0d valid %b busy %b required %0d 1 1", got_d.size(), tx_valid, busy, held);
      end
      tx_ready = 1'b1;
      wait_words(16, 100, "bp");
      repeat (4) tick();
      build_exp(0, 100, 2, 4);
      checks++;
      if (got_d.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count got %0d required %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL bp_word%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]);
         end
      end
      checks++;
      if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls required 0", stall_err); end
   endtask

   task automatic test_overflow();
      do_reset();
      tx_ready = 1'b0;
      complete = 1'b1;
      repeat (16) tick();
      checks++;
      if (pending !== 4'd15 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sat got pend %0d ovf %b required 15 0", pending, overflow);
      end
      tick();
      complete = 1'b0;
      checks++;
      if (pending !== 4'd15 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got pend %0d ovf %b required 15 1", pending, overflow);
      end
      repeat (3) tick();
      checks++;
      if (overflow !== 1'b1 || tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got ovf %b valid %b required 1 1", overflow, tx_valid);
      end
      live_rising = 1'b1;
      tick();
      live_rising = 1'b0;
      checks++;
      if (pending !== 4'd0 || overflow !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || even_rdaddr !== 15'd0) begin
         errors++;
         $display("FAIL ovf_live_clear got pend %0d ovf %b valid %b busy %b addr %0d required 0 0 0 0 0",
                  pending, overflow, tx_valid, busy, even_rdaddr);
      end
      tx_ready = 1'b1;
      repeat (10) tick();
      checks++;
      if (got_d.size() != 0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_discard got %0d words valid %b required 0 0", got_d.size(), tx_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tx_ready = 1'b1;
      pulse_complete(0);
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_valid, tx_last, busy, overflow} !== 4'b0 || tx_data !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_out got %b data %h required 0000 0000", {tx_valid, tx_last, busy, overflow}, tx_data);
      end
      checks++;
      if (even_rdaddr !== 15'd0 || odd_rdaddr !== 15'd0 || pending !== '0) begin
         errors++;
         $display("FAIL mid_reset_state got %0d/%0d pend %0d required 0/0 0", even_rdaddr, odd_rdaddr, pending);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_capture();
      pulse_complete(0);
      wait_words(8, 60, "mid");
      repeat (4) tick();
      build_exp(0, 100, 1, 4);
      checks++;
      if (got_d.size() != exp_q.size()) begin
         errors++;
         $display("FAIL mid_count got %0d required %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL mid_word%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_q[i], exp_l[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
